front_panel_input: RTL and testbench

Input-side front-panel block for the 10-bit processor: the counterpart to the display/output logic. It synchronizes and debounces the data switches and the two push buttons. On each Execute press it latches a 10-bit instruction/data word and issues a one-cycle execute pulse to the processor, then holds off further presses until the processor reports completion. It also supplies the clean, debounced Peek button level that drives the display's Bus/Reg toggle.

---
 rtl/front_panel_pkg.sv | 5 +
 rtl/front_panel_input_if.sv | 16 +
 rtl/button_debounce.sv | 37 +++
 rtl/front_panel_input.sv | 66 ++++++
 tb/tb_front_panel_input.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/front_panel_pkg.sv
// front_panel_pkg: shared data width and FSM state type for the front-panel input block
package front_panel_pkg;
   localparam int DATA_W = 10;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} fp_state_t;
endpackage

// File: rtl/front_panel_input_if.sv
// front_panel_input_if: panel/processor signals of front_panel_input
//   master: drives Switches, Execb_raw, Peekb_raw, Done; reads Din, Exec, Busy, Peekb
//   slave : the front_panel_input side of the same bundle
interface front_panel_input_if;
   import front_panel_pkg::*;
   logic [DATA_W-1:0] Switches;
   logic              Execb_raw;
   logic              Peekb_raw;
   logic              Done;
   logic [DATA_W-1:0] Din;
   logic              Exec;
   logic              Busy;
   logic              Peekb;
   modport master (output Switches, Execb_raw, Peekb_raw, Done, input Din, Exec, Busy, Peekb);
   modport slave  (input Switches, Execb_raw, Peekb_raw, Done, output Din, Exec, Busy, Peekb);
endinterface

// File: rtl/button_debounce.sv
// button_debounce: two-flop synchronizer plus counter debouncer for one active-low button
//   Clock, Reset : system clock, synchronous active-high reset
//   raw          : asynchronous bouncy button level
//   stable       : debounced level, released (1) after reset
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic Clock,
   input  logic Reset,
   input  logic raw,
   output logic stable
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   logic          s1_q, s2_q, stable_q, stable_d, differ, full;
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb begin
      differ   = s2_q != stable_q;
      full     = cnt_q == CW'(DEBOUNCE_CYCLES - 1);
      stable_d = differ && full ? ~stable_q : stable_q;
      cnt_d    = differ && !full ? cnt_q + 1'b1 : '0;
   end
   // Synchronizer resets to released so a button held through reset is seen as a fresh press
   always_ff @(posedge Clock) begin
      if (Reset) begin
         s1_q     <= 1'b1;
         s2_q     <= 1'b1;
         stable_q <= 1'b1;
         cnt_q    <= '0;
      end else begin
         s1_q     <= raw;
         s2_q     <= s1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end
   assign stable = stable_q;
endmodule

// File: rtl/front_panel_input.sv
// front_panel_input: debounced Execute/Peek buttons, switch capture and execute handshake
//   Clock, Reset : system clock, synchronous active-high reset
//   fp (slave)   : Switches/Execb_raw/Peekb_raw/Done in, Din/Exec/Busy/Peekb out
module front_panel_input
   import front_panel_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic                Clock,
   input  logic                Reset,
   front_panel_input_if.slave  fp
);
   logic [DATA_W-1:0] sw1_q, sw2_q, din_q, din_d;
   logic              exec_stable, exec_prev_q, done_q, done2_q, press, done_rise;
   fp_state_t         state_q, state_d;
   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exec (
      .Clock (Clock),
      .Reset (Reset),
      .raw   (fp.Execb_raw),
      .stable(exec_stable)
   );
   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_peek (
      .Clock (Clock),
      .Reset (Reset),
      .raw   (fp.Peekb_raw),
      .stable(fp.Peekb)
   );
   // Done is registered twice so a level already high on entry never looks like a rise
   always_comb begin
      press     = exec_prev_q & ~exec_stable;
      done_rise = done_q & ~done2_q;
      state_d   = state_q;
      din_d     = din_q;
      case (state_q)
         IDLE: begin
            state_d = press ? ISSUE : IDLE;
            din_d   = press ? sw2_q : din_q;
         end
         ISSUE:     state_d = WAIT_DONE;
         WAIT_DONE: state_d = done_rise ? IDLE : WAIT_DONE;
         default:   state_d = IDLE;
      endcase
   end
   always_ff @(posedge Clock) begin
      if (Reset) begin
         sw1_q       <= '0;
         sw2_q       <= '0;
         din_q       <= '0;
         exec_prev_q <= 1'b1;
         done_q      <= 1'b0;
         done2_q     <= 1'b0;
         state_q     <= IDLE;
      end else begin
         sw1_q       <= fp.Switches;
         sw2_q       <= sw1_q;
         din_q       <= din_d;
         exec_prev_q <= exec_stable;
         done_q      <= fp.Done;
         done2_q     <= done_q;
         state_q     <= state_d;
      end
   end
   assign fp.Din  = din_q;
   assign fp.Exec = state_q == ISSUE;
   assign fp.Busy = state_q != IDLE;
endmodule

// File: tb/tb_front_panel_input.sv
// tb_front_panel_input: directed scenarios plus random stimulus against a behavioural model
module tb_front_panel_input;
   localparam int DC = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   front_panel_input_if fp ();
   front_panel_input #(.DEBOUNCE_CYCLES(DC)) dut (
      .Clock(clk),
      .Reset(rst),
      .fp   (fp)
   );
   always #5 clk = ~clk;

   // Behavioural model: delays as sample queues, debounce as a run length of disagreeing samples
   logic [9:0] q_sw[$];
   logic       q_e[$], q_p[$], q_d[$];
   int         m_run_e, m_run_p, m_state;
   logic       m_st_e, m_st_p, m_fell;
   logic [9:0] m_din;
   always @(posedge clk) begin
      if (rst) begin
         q_sw = '{10'h0, 10'h0};
         q_e = '{1'b1, 1'b1};
         q_p = '{1'b1, 1'b1};
         q_d = '{1'b0, 1'b0};
         m_run_e = 0;
         m_run_p = 0;
         m_st_e = 1'b1;
         m_st_p = 1'b1;
         m_fell = 1'b0;
         m_din = '0;
         m_state = 0;
      end else begin
         if (m_state == 0 && m_fell) begin
            m_din = q_sw[0];
            m_state = 1;
         end else if (m_state == 1) m_state = 2;
         else if (m_state == 2 && q_d[1] && !q_d[0]) m_state = 0;
         m_fell = 1'b0;
         m_run_e = (q_e[0] !== m_st_e) ? m_run_e + 1 : 0;
         if (m_run_e == DC) begin
            m_st_e = ~m_st_e;
            m_run_e = 0;
            m_fell = !m_st_e;
         end
         m_run_p = (q_p[0] !== m_st_p) ? m_run_p + 1 : 0;
         if (m_run_p == DC) begin
            m_st_p = ~m_st_p;
            m_run_p = 0;
         end
         void'(q_sw.pop_front()); q_sw.push_back(fp.Switches);
         void'(q_e.pop_front());  q_e.push_back(fp.Execb_raw);
         void'(q_p.pop_front());  q_p.push_back(fp.Peekb_raw);
         void'(q_d.pop_front());  q_d.push_back(fp.Done);
      end
   end

   task automatic wait_exec(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(negedge clk);
         ok = fp.Exec;
      end
   endtask

   task automatic finish_instr();
      fp.Done = 1'b1;
      repeat (2) @(negedge clk);
      fp.Done = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      fp.Switches = 10'h3FF;
      fp.Execb_raw = 1'b1;
      fp.Peekb_raw = 1'b1;
      fp.Done = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (fp.Din !== 10'h0) begin errors++; $display("FAIL reset_din got %h want 000", fp.Din); end
      checks++; if (fp.Exec !== 1'b0) begin errors++; $display("FAIL reset_exec got %b want 0", fp.Exec); end
      checks++; if (fp.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", fp.Busy); end
      checks++; if (fp.Peekb !== 1'b1) begin errors++; $display("FAIL reset_peekb got %b want 1", fp.Peekb); end
      rst = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_clean_press();
      fp.Switches = 10'h2A5;
      fp.Execb_raw = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         checks++; if (fp.Exec !== (i == 7)) begin errors++; $display("FAIL clean_exec edge %0d got %b want %b", i, fp.Exec, i == 7); end
         checks++; if (fp.Busy !== (i >= 7)) begin errors++; $display("FAIL clean_busy edge %0d got %b want %b", i, fp.Busy, i >= 7); end
         if (i == 7) begin
            checks++; if (fp.Din !== 10'h2A5) begin errors++; $display("FAIL clean_din got %h want 2a5", fp.Din); end
         end
      end
      fp.Execb_raw = 1'b1;
      finish_instr();
      repeat (8) @(negedge clk);
   endtask

   task automatic test_bounce();
      logic [9:0] prev;
      int n;
      prev = fp.Din;
      n = 0;
      fp.Switches = 10'h0AA;
      for (int i = 0; i < 12; i++) begin
         fp.Execb_raw = ((i / 2) % 2) != 0;
         @(negedge clk);
         n += int'(fp.Exec);
      end
      fp.Execb_raw = 1'b1;
      repeat (10) begin @(negedge clk); n += int'(fp.Exec); end
      checks++; if (n !== 0) begin errors++; $display("FAIL bounce_exec got %0d pulses want 0", n); end
      checks++; if (fp.Busy !== 1'b0) begin errors++; $display("FAIL bounce_busy got %b want 0", fp.Busy); end
      checks++; if (fp.Din !== prev) begin errors++; $display("FAIL bounce_din got %h want %h", fp.Din, prev); end
   endtask

   task automatic test_handshake();
      bit ok;
      int n;
      fp.Switches = 10'h155;
      fp.Execb_raw = 1'b0;
      wait_exec(ok);
      checks++; if (!ok) begin errors++; $display("FAIL hs_exec1 timeout got 0 want 1"); end
      checks++; if (fp.Din !== 10'h155) begin errors++; $display("FAIL hs_din1 got %h want 155", fp.Din); end
      fp.Execb_raw = 1'b1;
      repeat (10) @(negedge clk);
      fp.Done = 1'b1;
      @(negedge clk);
      checks++; if (fp.Busy !== 1'b1) begin errors++; $display("FAIL hs_busy_k got %b want 1", fp.Busy); end
      @(negedge clk);
      checks++; if (fp.Busy !== 1'b0) begin errors++; $display("FAIL hs_busy_k1 got %b want 0", fp.Busy); end
      fp.Done = 1'b0;
      repeat (4) @(negedge clk);
      fp.Switches = 10'h0F0;
      fp.Execb_raw = 1'b0;
      n = 0;
      repeat (16) begin @(negedge clk); n += int'(fp.Exec); end
      checks++; if (n !== 1) begin errors++; $display("FAIL hs_exec2 got %0d pulses want 1", n); end
      checks++; if (fp.Din !== 10'h0F0) begin errors++; $display("FAIL hs_din2 got %h want 0f0", fp.Din); end
      fp.Execb_raw = 1'b1;
      finish_instr();
      repeat (8) @(negedge clk);
   endtask

   task automatic test_busy_reject();
      bit ok;
      int n;
      fp.Switches = 10'h111;
      fp.Execb_raw = 1'b0;
      wait_exec(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rej_exec1 timeout got 0 want 1"); end
      fp.Execb_raw = 1'b1;
      repeat (10) @(negedge clk);
      fp.Switches = 10'h222;
      fp.Execb_raw = 1'b0;
      n = 0;
      repeat (10) begin @(negedge clk); n += int'(fp.Exec); end
      fp.Execb_raw = 1'b1;
      repeat (10) begin @(negedge clk); n += int'(fp.Exec); end
      checks++; if (n !== 0) begin errors++; $display("FAIL rej_exec2 got %0d pulses want 0", n); end
      checks++; if (fp.Busy !== 1'b1) begin errors++; $display("FAIL rej_busy got %b want 1", fp.Busy); end
      checks++; if (fp.Din !== 10'h111) begin errors++; $display("FAIL rej_din got %h want 111", fp.Din); end
      fp.Done = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (fp.Busy !== 1'b0) begin errors++; $display("FAIL rej_done1 got %b want 0", fp.Busy); end
      fp.Switches = 10'h333;
      fp.Execb_raw = 1'b0;
      wait_exec(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rej_exec3 timeout got 0 want 1"); end
      fp.Execb_raw = 1'b1;
      repeat (10) @(negedge clk);
      checks++; if (fp.Busy !== 1'b1) begin errors++; $display("FAIL rej_done_high got %b want 1", fp.Busy); end
      fp.Done = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (fp.Busy !== 1'b1) begin errors++; $display("FAIL rej_done_low got %b want 1", fp.Busy); end
      fp.Done = 1'b1;
      @(negedge clk);
      checks++; if (fp.Busy !== 1'b1) begin errors++; $display("FAIL rej_rise_k got %b want 1", fp.Busy); end
      @(negedge clk);
      checks++; if (fp.Busy !== 1'b0) begin errors++; $display("FAIL rej_rise_k1 got %b want 0", fp.Busy); end
      fp.Done = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_peek();
      int n;
      n = 0;
      fp.Peekb_raw = 1'b0;
      repeat (3) begin @(negedge clk); n += int'(!fp.Peekb); end
      fp.Peekb_raw = 1'b1;
      repeat (10) begin @(negedge clk); n += int'(!fp.Peekb); end
      checks++; if (n !== 0) begin errors++; $display("FAIL peek_glitch got %0d low cycles want 0", n); end
      fp.Peekb_raw = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         checks++; if (fp.Peekb !== !(i >= 6 && i < 14)) begin errors++; $display("FAIL peek_level edge %0d got %b want %b", i, fp.Peekb, !(i >= 6 && i < 14)); end
         if (i == 8) fp.Peekb_raw = 1'b1;
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      fp.Switches = 10'h3C3;
      fp.Execb_raw = 1'b0;
      fp.Peekb_raw = 1'b0;
      wait_exec(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rm_exec1 timeout got 0 want 1"); end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      fp.Peekb_raw = 1'b1;
      checks++; if (fp.Busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b want 0", fp.Busy); end
      checks++; if (fp.Exec !== 1'b0) begin errors++; $display("FAIL rm_exec got %b want 0", fp.Exec); end
      checks++; if (fp.Din !== 10'h0) begin errors++; $display("FAIL rm_din got %h want 000", fp.Din); end
      checks++; if (fp.Peekb !== 1'b1) begin errors++; $display("FAIL rm_peekb got %b want 1", fp.Peekb); end
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         checks++; if (fp.Exec !== (i == 7)) begin errors++; $display("FAIL rm_reexec edge %0d got %b want %b", i, fp.Exec, i == 7); end
      end
      checks++; if (fp.Din !== 10'h3C3) begin errors++; $display("FAIL rm_din2 got %h want 3c3", fp.Din); end
      fp.Execb_raw = 1'b1;
      finish_instr();
      repeat (8) @(negedge clk);
   endtask

   task automatic test_random();
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         checks++; if (fp.Exec !== (m_state == 1)) begin errors++; $display("FAIL rnd_exec cyc %0d got %b want %b", i, fp.Exec, m_state == 1); end
         checks++; if (fp.Busy !== (m_state != 0)) begin errors++; $display("FAIL rnd_busy cyc %0d got %b want %b", i, fp.Busy, m_state != 0); end
         checks++; if (fp.Din !== m_din) begin errors++; $display("FAIL rnd_din cyc %0d got %h want %h", i, fp.Din, m_din); end
         checks++; if (fp.Peekb !== m_st_p) begin errors++; $display("FAIL rnd_peekb cyc %0d got %b want %b", i, fp.Peekb, m_st_p); end
         fp.Switches = 10'($urandom);
         if ($urandom_range(5) == 0) fp.Execb_raw = ~fp.Execb_raw;
         if ($urandom_range(5) == 0) fp.Peekb_raw = ~fp.Peekb_raw;
         if ($urandom_range(7) == 0) fp.Done = ~fp.Done;
         rst = $urandom_range(999) == 0;
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_handshake();
      test_busy_reject();
      test_peek();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
